// File: rtl/mgr_sync_barrier_if.sv
// Manager-side barrier handshake bundle: per-manager request, release pulse and ready mask.
interface mgr_sync_barrier_if #(
    parameter int unsigned NUM_MGR = 64
);
    logic [NUM_MGR-1:0] mgr__sys__allSynchronized;
    logic [NUM_MGR-1:0] sys__mgr__thisSynchronized;
    logic [NUM_MGR-1:0] sys__mgr__ready;

    modport master (
        output mgr__sys__allSynchronized,
        input  sys__mgr__thisSynchronized,
        input  sys__mgr__ready
    );

    modport slave (
        input  mgr__sys__allSynchronized,
        output sys__mgr__thisSynchronized,
        output sys__mgr__ready
    );
endinterface

// File: rtl/mgr_sync_barrier.sv
// Barrier sync controller: collects masked manager requests, releases them with a one-cycle pulse.
// Optional timeout monitor enabled by defining MGR_SYNC_TIMEOUT_EN.
module mgr_sync_barrier #(
    parameter int unsigned NUM_MGR   = 64,
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_poweron,
    mgr_sync_barrier_if.slave    mgr_if,
    input  logic [NUM_MGR-1:0]   sys__sync__enMask,
    output logic [15:0]          sync__sys__barrierCount,
    output logic                 sync__sys__idle,
    input  logic [TIMEOUT_W-1:0] sys__sync__timeoutLimit,
    input  logic                 sys__sync__clearErr,
    output logic                 sync__sys__timeout,
    output logic [NUM_MGR-1:0]   sync__sys__missing
);

    typedef enum logic [1:0] {StInit, StCollect, StRelease, StDrain} state_e;

    state_e             state_q, state_d;
    logic [NUM_MGR-1:0] mask_q, mask_d;
    logic [NUM_MGR-1:0] arrived_q, arrived_d;
    logic [NUM_MGR-1:0] dropped_q, dropped_d;
    logic [15:0]        count_q, count_d;
    logic [NUM_MGR-1:0] this_sync_q, this_sync_d;
    logic [NUM_MGR-1:0] ready_q, ready_d;
    logic               idle_q, idle_d;

    logic [NUM_MGR-1:0] req;
    logic [NUM_MGR-1:0] arrived_next;
    logic [NUM_MGR-1:0] dropped_next;

    assign req          = mgr_if.mgr__sys__allSynchronized;
    assign arrived_next = arrived_q | (req & mask_q);
    assign dropped_next = dropped_q | (~req & mask_q);

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        arrived_d = arrived_q;
        dropped_d = dropped_q;
        count_d   = count_q;
        unique case (state_q)
            StInit: begin
                mask_d    = sys__sync__enMask;
                arrived_d = '0;
                dropped_d = '0;
                state_d   = StCollect;
            end
            StCollect: begin
                arrived_d = arrived_next;
                if ((mask_q != '0) && (&(arrived_next | ~mask_q))) begin
                    state_d = StRelease;
                end
            end
            StRelease: begin
                count_d   = count_q + 16'd1;
                dropped_d = ~req & mask_q;
                state_d   = StDrain;
            end
            StDrain: begin
                dropped_d = dropped_next;
                if (&(dropped_next | ~mask_q)) begin
                    mask_d = sys__sync__enMask;
                    // Keep an early re-request from a fast manager for the next barrier.
                    arrived_d = req & sys__sync__enMask;
                    state_d   = StCollect;
                end
            end
            default: state_d = StInit;
        endcase

        // Outputs are registered, so decode them from the next state.
        this_sync_d = (state_d == StRelease) ? mask_d : '0;
        ready_d     = (state_d != StInit) ? mask_d : '0;
        idle_d      = (state_d == StCollect) && ((arrived_d & mask_d) == '0);
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            state_q     <= StInit;
            mask_q      <= '0;
            arrived_q   <= '0;
            dropped_q   <= '0;
            count_q     <= '0;
            this_sync_q <= '0;
            ready_q     <= '0;
            idle_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            arrived_q   <= arrived_d;
            dropped_q   <= dropped_d;
            count_q     <= count_d;
            this_sync_q <= this_sync_d;
            ready_q     <= ready_d;
            idle_q      <= idle_d;
        end
    end

    assign mgr_if.sys__mgr__thisSynchronized = this_sync_q;
    assign mgr_if.sys__mgr__ready            = ready_q;
    assign sync__sys__barrierCount           = count_q;
    assign sync__sys__idle                   = idle_q;

`ifdef MGR_SYNC_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic                 timeout_q, timeout_d;
    logic [NUM_MGR-1:0]   missing_q, missing_d;
    logic                 pending;
    logic                 limit_on;

    assign limit_on = (sys__sync__timeoutLimit != '0);
    // Partially arrived barrier that is not completing this cycle.
    assign pending  = (state_q == StCollect) && (state_d == StCollect) &&
                      ((arrived_d & mask_q) != '0);

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        timeout_d = timeout_q;
        missing_d = missing_q;
        if (sys__sync__clearErr) begin
            timeout_d = 1'b0;
            missing_d = '0;
        end
        if (state_d != StCollect) begin
            tmo_cnt_d = '0;
        end else if (pending && !(limit_on && (tmo_cnt_q == sys__sync__timeoutLimit))) begin
            tmo_cnt_d = tmo_cnt_q + TIMEOUT_W'(1);
            // A new timeout overrides a simultaneous clear.
            if (limit_on && (tmo_cnt_d == sys__sync__timeoutLimit)) begin
                timeout_d = 1'b1;
                missing_d = mask_q & ~arrived_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
            missing_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
            missing_q <= missing_d;
        end
    end

    assign sync__sys__timeout = timeout_q;
    assign sync__sys__missing = missing_q;
`else
    logic unused_tmo_inputs;
    assign unused_tmo_inputs  = ^{sys__sync__timeoutLimit, sys__sync__clearErr};
    assign sync__sys__timeout = 1'b0;
    assign sync__sys__missing = '0;
`endif

endmodule

// File: tb/tb_mgr_sync_barrier.sv
// Scoreboard bench for mgr_sync_barrier: directed scenarios plus randomized manager traffic.
module tb_mgr_sync_barrier;

    localparam int unsigned N  = 4;
    localparam int unsigned TW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mgr_sync_barrier_if #(.NUM_MGR(N)) mif ();

    logic [N-1:0]  req = '0;
    logic [N-1:0]  en = 4'hF;
    logic [15:0]   cnt_o;
    logic          idle_o;
    logic [TW-1:0] lim = '0;
    logic          clr = 1'b0;
    logic          tmo_o;
    logic [N-1:0]  miss_o;

    assign mif.mgr__sys__allSynchronized = req;

    mgr_sync_barrier #(.NUM_MGR(N), .TIMEOUT_W(TW)) dut (
        .clk                     (clk),
        .reset_poweron           (rst_n),
        .mgr_if                  (mif.slave),
        .sys__sync__enMask       (en),
        .sync__sys__barrierCount (cnt_o),
        .sync__sys__idle         (idle_o),
        .sys__sync__timeoutLimit (lim),
        .sys__sync__clearErr     (clr),
        .sync__sys__timeout      (tmo_o),
        .sync__sys__missing      (miss_o)
    );

    int n_chk = 0;
    int n_fail = 0;
    int rel_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {MInit, MCollect, MRelease, MDrain} mphase_e;
    typedef struct {logic [N-1:0] rel; int at;} exp_t;

    mphase_e     ph;
    bit          m_mask[N];
    bit          m_arr[N];
    bit          m_drop[N];
    logic [15:0] m_count;
    int          cyc;
    exp_t        expq[$];

    function automatic logic [N-1:0] pack(input bit b[N]);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = b[i];
        return v;
    endfunction

    task automatic model_reset();
        ph = MInit;
        m_count = '0;
        for (int i = 0; i < N; i++) begin
            m_mask[i] = 0;
            m_arr[i]  = 0;
            m_drop[i] = 0;
        end
        expq.delete();
    endtask

    task automatic model_step();
        bit any;
        bit all;
        exp_t e;
        case (ph)
            MInit: begin
                for (int i = 0; i < N; i++) begin
                    m_mask[i] = en[i];
                    m_arr[i]  = 0;
                end
                ph = MCollect;
            end
            MCollect: begin
                any = 0;
                all = 1;
                for (int i = 0; i < N; i++) begin
                    if (m_mask[i] && req[i]) m_arr[i] = 1;
                    if (m_mask[i]) any = 1;
                    if (m_mask[i] && !m_arr[i]) all = 0;
                end
                if (any && all) begin
                    e.rel = pack(m_mask);
                    e.at  = cyc;
                    expq.push_back(e);
                    ph = MRelease;
                end
            end
            MRelease: begin
                m_count = m_count + 16'd1;
                for (int i = 0; i < N; i++) m_drop[i] = m_mask[i] && !req[i];
                ph = MDrain;
            end
            MDrain: begin
                all = 1;
                for (int i = 0; i < N; i++) begin
                    if (m_mask[i] && !req[i]) m_drop[i] = 1;
                    if (m_mask[i] && !m_drop[i]) all = 0;
                end
                if (all) begin
                    for (int i = 0; i < N; i++) begin
                        m_mask[i] = en[i];
                        m_arr[i]  = req[i] && en[i];
                    end
                    ph = MCollect;
                end
            end
            default: ph = MInit;
        endcase
    endtask

    initial begin
        cyc = 0;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                cyc++;
                model_step();
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        logic [N-1:0] exp_ready;
        logic exp_idle;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mif.sys__mgr__thisSynchronized !== '0) begin
                    rel_seen++;
                    if (expq.size() == 0) begin
                        chk("unexpected_release", 32'(mif.sys__mgr__thisSynchronized), 0);
                    end else begin
                        e = expq.pop_front();
                        chk("release_mask", 32'(mif.sys__mgr__thisSynchronized), 32'(e.rel));
                        chk("release_cycle", cyc, e.at);
                    end
                end else if (expq.size() > 0 && cyc >= expq[0].at) begin
                    e = expq.pop_front();
                    chk("release_missing", 32'(mif.sys__mgr__thisSynchronized), 32'(e.rel));
                end
                exp_ready = (ph == MInit) ? '0 : pack(m_mask);
                exp_idle  = (ph == MCollect) && ((pack(m_arr) & pack(m_mask)) == '0);
                chk("ready", 32'(mif.sys__mgr__ready), 32'(exp_ready));
                chk("count", 32'(cnt_o), 32'(m_count));
                chk("idle", 32'(idle_o), 32'(exp_idle));
`ifndef MGR_SYNC_TIMEOUT_EN
                chk("timeout_tied", 32'(tmo_o), 0);
                chk("missing_tied", 32'(miss_o), 0);
`endif
            end
        end
    end

    // ---------------- manager drivers ----------------
    bit rnd = 0;
    int raise_in[N];
    int hold[N];
    bit got_rel[N];
    int post_hold[N];
    int post_raise[N];

    initial begin
        for (int i = 0; i < N; i++) begin
            raise_in[i] = -1; hold[i] = 0; got_rel[i] = 0;
            post_hold[i] = 0; post_raise[i] = -1;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!rst_n) begin
                    req[i] = 1'b0; raise_in[i] = -1; got_rel[i] = 0;
                end else if (req[i]) begin
                    if (mif.sys__mgr__thisSynchronized[i]) begin
                        got_rel[i] = 1;
                        hold[i] = rnd ? int'($urandom_range(0, 2)) : post_hold[i];
                    end
                    if (got_rel[i]) begin
                        if (hold[i] == 0) begin
                            req[i] = 1'b0;
                            got_rel[i] = 0;
                            raise_in[i] = rnd ? int'($urandom_range(1, 5)) : post_raise[i];
                        end else begin
                            hold[i]--;
                        end
                    end
                end else if (raise_in[i] > 0) begin
                    raise_in[i]--;
                    if (raise_in[i] == 0) begin
                        req[i] = 1'b1;
                        raise_in[i] = -1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_rel(input int target, input int budget);
        int k;
        k = 0;
        while (rel_seen < target && k < budget) begin
            step(1);
            k++;
        end
        if (rel_seen < target) chk("wait_release_expired", rel_seen, target);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_release"}, 32'(mif.sys__mgr__thisSynchronized), 0);
        chk({tag, "_ready"}, 32'(mif.sys__mgr__ready), 0);
        chk({tag, "_count"}, 32'(cnt_o), 0);
        chk({tag, "_idle"}, 32'(idle_o), 0);
        chk({tag, "_timeout"}, 32'(tmo_o), 0);
        chk({tag, "_missing"}, 32'(miss_o), 0);
    endtask

    task automatic do_reset(input logic [N-1:0] new_en);
        step(1);
        rst_n = 1'b0;
        en = new_en;
        for (int i = 0; i < N; i++) post_raise[i] = -1;
        for (int i = 0; i < N; i++) post_hold[i] = 0;
        #1;
        check_zero_outputs("reset");
        step(2);
        rst_n = 1'b1;
    endtask

    int base;
    int k;

    initial begin
        #1;
        check_zero_outputs("por");
        #21;
        rst_n = 1'b1;

        // Basic barrier: staggered arrivals, single release.
        step(1);
        raise_in[0] = 10; raise_in[1] = 12; raise_in[2] = 15; raise_in[3] = 20;
        wait_rel(1, 60);
        step(3);
        chk("basic_count", 32'(cnt_o), 1);
        chk("basic_pulses", rel_seen, 1);

        // Masking: manager 1 alone never releases a 0x5 barrier.
        do_reset(4'h5);
        base = rel_seen;
        raise_in[1] = 1;
        step(30);
        chk("mask_no_release", rel_seen, base);
        raise_in[0] = 2; raise_in[2] = 5;
        wait_rel(base + 1, 30);
        step(3);
        chk("mask_count", 32'(cnt_o), 1);

        // Fast re-request: manager 0 re-raises while manager 3 still holds.
        do_reset(4'hF);
        base = rel_seen;
        post_hold[3] = 4; post_raise[0] = 1;
        post_raise[1] = 8; post_raise[2] = 8; post_raise[3] = 8;
        for (int i = 0; i < N; i++) raise_in[i] = 2;
        wait_rel(base + 1, 30);
        k = 0;
        while (req[3] && k < 20) begin
            step(1);
            k++;
        end
        chk("fast_mgr3_dropped", 32'(req[3]), 0);
        step(2);
        chk("fast_rereq_not_idle", 32'(idle_o), 0);
        wait_rel(base + 2, 30);
        for (int i = 0; i < N; i++) post_raise[i] = -1;

        // Reset mid-barrier abandons the barrier.
        do_reset(4'hF);
        base = rel_seen;
        raise_in[0] = 1; raise_in[1] = 1; raise_in[2] = 1;
        step(5);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        step(2);
        rst_n = 1'b1;
        raise_in[0] = 1; raise_in[1] = 1; raise_in[2] = 1;
        step(15);
        chk("midreset_no_release", rel_seen, base);
        chk("midreset_count", 32'(cnt_o), 0);
        raise_in[3] = 1;
        wait_rel(base + 1, 20);
        step(3);
        chk("midreset_count_after", 32'(cnt_o), 1);

        // Counter wrap from 0xFFFF.
        do_reset(4'hF);
        step(2);
        force dut.count_q = 16'hFFFF;
        m_count = 16'hFFFF;
        step(1);
        release dut.count_q;
        base = rel_seen;
        for (int i = 0; i < N; i++) raise_in[i] = 1;
        wait_rel(base + 1, 20);
        step(3);
        chk("wrap_count", 32'(cnt_o), 0);

`ifdef MGR_SYNC_TIMEOUT_EN
        // Timeout: manager 3 absent, flag is sticky until cleared.
        do_reset(4'hF);
        lim = 16'd8;
        base = rel_seen;
        raise_in[0] = 1; raise_in[1] = 1; raise_in[2] = 1;
        k = 0;
        while (!tmo_o && k < 30) begin
            step(1);
            k++;
        end
        chk("tmo_flag", 32'(tmo_o), 1);
        chk("tmo_missing", 32'(miss_o), 32'h8);
        raise_in[3] = 1;
        wait_rel(base + 1, 20);
        chk("tmo_sticky", 32'(tmo_o), 1);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        step(1);
        chk("tmo_cleared", 32'(tmo_o), 0);
        chk("tmo_missing_cleared", 32'(miss_o), 0);
        lim = '0;
`endif

        // Randomized traffic with occasional mask changes.
        do_reset(4'hF);
        base = rel_seen;
        rnd = 1;
        for (int i = 0; i < N; i++) raise_in[i] = int'($urandom_range(1, 5));
        for (int r = 0; r < 15; r++) begin
            en = 4'($urandom_range(1, 15));
            step(100);
        end
        rnd = 0;
        step(20);
        chk("random_progress", 32'(rel_seen > base + 10), 1);
        chk("queue_drained", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
